bin2bcd_arbiter: RTL

Round-robin front end that shares one `bin2bcd` converter among `N` requesters. Each requester presents a binary word with a valid/ready handshake. The block sequences the converter's `start`/`done_tick` protocol and returns the 16-bit BCD result, tagged with the requester index. It sits between the display/report clients and the single `bin2bcd` instance, which it owns.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bin2bcd.sv | 70 +++++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/bin2bcd_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the bin2bcd arbiter slice.
//   arb_state_t : arbiter FSM encoding (also exported on the debug port)
//   BCD_W       : width of a 4-digit packed BCD result
//   W_MAX       : widest binary word whose value always fits in 4 BCD digits
//   add3_digit  : double-dabble digit correction step
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int BCD_W = 16;
    localparam int W_MAX = 13;

    // A digit of 5 or more would overflow past 9 when doubled by the next
    // shift, so it is pre-biased by 3 to carry into the next digit instead.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Iterative double-dabble binary to BCD converter.
// One bit of the input word is shifted in per cycle, so a conversion takes
// W cycles after start, and done_tick follows in the next cycle.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a conversion of bin (accepted only while ready)
//   bin        : binary word, W bits (W <= W_MAX)
//   ready      : converter idle, start will be accepted
//   done_tick  : one-cycle pulse, bcd holds the finished result
//   bcd        : 4-digit packed BCD result, MS digit in [15:12]
module bin2bcd
    import bcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             ready,
    output logic             done_tick,
    output logic [BCD_W-1:0] bcd
);

    localparam int CW = $clog2(W + 1);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     sh;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj;
    logic             done_r;

    always_comb begin
        adj = {add3_digit(acc[15:12]), add3_digit(acc[11:8]),
               add3_digit(acc[7:4]),   add3_digit(acc[3:0])};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            sh      <= '0;
            acc     <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!running) begin
                if (start) begin
                    running <= 1'b1;
                    cnt     <= '0;
                    sh      <= bin;
                    acc     <= '0;
                end
            end else begin
                acc <= {adj[BCD_W-2:0], sh[W-1]};
                sh  <= sh << 1;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    running <= 1'b0;
                    done_r  <= 1'b1;
                end
            end
        end
    end

    assign ready     = !running;
    assign done_tick = done_r;
    assign bcd       = acc;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at index ptr and wrapping modulo N; the first set
// bit wins. The pointer itself is held by the parent.
//   req    : N request bits
//   ptr    : search start index
//   en     : when low no grant is produced
//   gnt    : one-hot grant (all zero when no grant)
//   gnt_id : encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/bin2bcd_arbiter.sv
// Round-robin front end sharing one bin2bcd converter among N requesters.
//
// Handshake: a requester holds req_valid[i] high with req_bin stable until
// it sees req_ready[i] high in the same cycle; the transfer happens on that
// rising edge. req_ready is one-hot, only ever asserted in IDLE while the
// converter is ready, and is combinational from req_valid/ptr/state.
// The result is presented by a one-cycle rsp_valid pulse with no
// back-pressure; rsp_id/rsp_bcd hold until the next result is captured.
//
//   clk, reset     : clock, asynchronous active-high reset (also resets converter)
//   req_valid      : N pending-request bits
//   req_bin        : N flattened W-bit words, requester i at [i*W +: W]
//   req_ready      : one-hot grant
//   rsp_valid      : one-cycle result pulse
//   rsp_id         : index of the requester owning the result
//   rsp_bcd        : 4-digit BCD result
//   busy           : high whenever the FSM is not in IDLE
//   conv_count     : completed conversions, wraps at 16 bits
//   cnt_preset     : load conv_count from cnt_preset_val (bring-up/debug hook)
//   cnt_preset_val : value loaded by cnt_preset
//   state_dbg      : current FSM state
module bin2bcd_arbiter
    import bcd_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int W   = 8,
    localparam int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_bin,
    input  logic             cnt_preset,
    input  logic [15:0]      cnt_preset_val,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [BCD_W-1:0] rsp_bcd,
    output logic             busy,
    output logic [15:0]      conv_count,
    output arb_state_t       state_dbg
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDW-1:0]   ptr;
    logic [W-1:0]     bin_q;
    logic [IDW-1:0]   id_q;

    logic             conv_start;
    logic             conv_ready;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic             arb_en;
    logic [N-1:0]     arb_gnt;
    logic [IDW-1:0]   arb_id;
    logic             hs;

    // Gating on reset keeps req_ready low during reset even though the
    // state register already reads IDLE.
    assign arb_en = (state == IDLE) && conv_ready && !reset;

    rr_arbiter #(.N(N)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    // The arbiter only grants valid requesters, so any grant is a transfer.
    assign hs        = |arb_gnt;
    assign req_ready = arb_gnt;

    assign conv_start = (state == START);

    bin2bcd #(.W(W)) u_conv (
        .clk       (clk),
        .reset     (reset),
        .start     (conv_start),
        .bin       (bin_q),
        .ready     (conv_ready),
        .done_tick (conv_done),
        .bcd       (conv_bcd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (conv_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            bin_q      <= '0;
            id_q       <= '0;
            rsp_id     <= '0;
            rsp_bcd    <= '0;
            conv_count <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                bin_q <= req_bin[arb_id*W +: W];
                id_q  <= arb_id;
                ptr   <= (arb_id == IDW'(N - 1)) ? '0 : arb_id + IDW'(1);
            end
            if (state == WAIT && conv_done) begin
                rsp_bcd <= conv_bcd;
                rsp_id  <= id_q;
            end
            if (cnt_preset) begin
                conv_count <= cnt_preset_val;
            end else if (state == WAIT && conv_done) begin
                conv_count <= conv_count + 16'd1;
            end
        end
    end

    // Decoded straight from the state register, so these behave as
    // registered outputs.
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
